// File: rtl/arb_rr4.sv
// arb_rr4 : four-requester round-robin arbiter with registered one-hot grant.
//
// A grant is held until the owner drops its request, or until the arbiter is
// disabled. Priority then rotates to the requester after the last owner.
// Exactly one idle cycle separates consecutive owners.
//
// Optional feature (macro ARB_RR4_TIMEOUT_EN):
//   defined   - an 8-bit hold counter revokes a grant after MAX_HOLD
//               consecutive cycles and pulses `timeout` for one cycle.
//   undefined - grants are unbounded, `timeout` is tied low, and MAX_HOLD
//               has no effect.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   en       in   arbiter enable; 0 forces release / no new grant
//   req[3:0] in   level request vector, bit i = requester i
//   gnt[3:0] out  registered one-hot grant or 0000
//   gnt_idx  out  registered index of current or last owner
//   valid    out  registered, equals |gnt
//   timeout  out  one-cycle pulse after a watchdog revocation
module arb_rr4 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       valid,
   output logic       timeout
);

   typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_e;

   state_e     state_q, state_d;
   logic [1:0] ptr_q,   ptr_d;
   logic [3:0] gnt_q,   gnt_d;
   logic [1:0] idx_q,   idx_d;
   logic       valid_q, valid_d;
   logic       expire;

   // Rotate the request vector so that bit 0 is the requester at ptr; the
   // first set bit of the rotated vector is then the round-robin winner.
   logic [7:0] req_dbl;
   logic [3:0] req_rot;
   logic [1:0] pick_off;
   logic [1:0] pick_idx;

   assign req_dbl = {req, req} >> ptr_q;
   assign req_rot = req_dbl[3:0];

   always_comb begin
      pick_off = 2'd0;
      casez (req_rot)
         4'b???1: pick_off = 2'd0;
         4'b??10: pick_off = 2'd1;
         4'b?100: pick_off = 2'd2;
         4'b1000: pick_off = 2'd3;
         default: pick_off = 2'd0;
      endcase
   end

   assign pick_idx = ptr_q + pick_off;

`ifdef ARB_RR4_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;
   logic       to_q;

   // hold_q counts completed GRANT cycles of the current owner, so it reads
   // MAX_HOLD-1 during the MAX_HOLD-th cycle, which is the last one allowed.
   assign expire = (state_q == S_GRANT) && (hold_q == 8'(MAX_HOLD - 1));

   always_comb begin
      hold_d = 8'd0;
      if (state_q == S_GRANT && state_d == S_GRANT) begin
         hold_d = hold_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q <= 8'd0;
         to_q   <= 1'b0;
      end else begin
         hold_q <= hold_d;
         to_q   <= expire;
      end
   end

   assign timeout = to_q;
`else
   // No watchdog in this build; MAX_HOLD is kept only so parameterised
   // instantiations remain valid.
   logic unused_max_hold;
   assign unused_max_hold = ^8'(MAX_HOLD);
   assign expire          = 1'b0;
   assign timeout         = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (en && (req != 4'b0000)) begin
               state_d = S_GRANT;
               gnt_d   = 4'b0001 << pick_idx;
               idx_d   = pick_idx;
               valid_d = 1'b1;
            end else begin
               gnt_d   = 4'b0000;
               valid_d = 1'b0;
            end
         end
         S_GRANT: begin
            // Watchdog expiry takes the same release path as a normal drop.
            if (expire || !en || !req[idx_q]) begin
               state_d = S_IDLE;
               gnt_d   = 4'b0000;
               valid_d = 1'b0;
               ptr_d   = idx_q + 2'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= 2'd0;
         gnt_q   <= 4'b0000;
         idx_q   <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_arb_rr4.sv
// Testbench for arb_rr4: vector table, fairness / timeout sequences and
// randomized traffic against a behavioural round-robin model.
module tb_arb_rr4;

   localparam int MAXH = 4;
`ifdef ARB_RR4_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       valid;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   arb_rr4 #(.MAX_HOLD(MAXH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .valid   (valid),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: owner is -1 when nobody holds the resource.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_last  = 0;
   int m_held  = 0;
   bit m_to    = 1'b0;

   function automatic void model(input bit r, input bit e, input logic [3:0] rq);
      bit found;
      bit wd;
      int c;
      if (!r) begin
         m_owner = -1; m_ptr = 0; m_last = 0; m_held = 0; m_to = 1'b0;
      end else if (m_owner < 0) begin
         m_to  = 1'b0;
         found = 1'b0;
         if (e && rq != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
               c = (m_ptr + k) % 4;
               if (!found && rq[c]) begin
                  found   = 1'b1;
                  m_owner = c;
                  m_last  = c;
                  m_held  = 1;
               end
            end
         end
      end else begin
         wd = TO_EN && (m_held >= MAXH);
         if (wd || !e || !rq[m_owner]) begin
            m_to    = wd;
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
         end else begin
            m_held = m_held + 1;
         end
      end
   endfunction

   function automatic int exp_gnt();
      return (m_owner < 0) ? 0 : (1 << m_owner);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare after the edge.
   task automatic step(input logic r, input logic e, input logic [3:0] rq);
      rst_n = r; en = e; req = rq;
      @(posedge clk);
      model(r, e, rq);
      #1;
      chk("model_gnt", int'(gnt), exp_gnt());
      chk("model_idx", int'(gnt_idx), m_last);
      chk("model_valid", int'(valid), (m_owner >= 0) ? 1 : 0);
      chk("model_timeout", int'(timeout), int'(m_to));
      chk("onehot", int'($countones(gnt) <= 1), 1);
   endtask

   typedef struct {
      logic       r;
      logic       e;
      logic [3:0] rq;
      logic [3:0] g;
      logic [1:0] idx;
      logic       v;
   } vec_t;

   vec_t tbl[15];
   int   obs_g[$];
   int   obs_t[$];
   logic [3:0] rq_f;
   logic [3:0] rq_r;
   int   zeros;
   int   nruns;

   initial begin
      rst_n = 1'b0; en = 1'b0; req = 4'b0000;

      // Expected values after the edge at which each row is applied.
      tbl[0]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 4'b1001, 4'b0000, 2'd3, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd3, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd1, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1};

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].rq);
         chk($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].g));
         chk($sformatf("tbl%0d_idx", i), int'(gnt_idx), int'(tbl[i].idx));
         chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].v));
         chk($sformatf("tbl%0d_timeout", i), int'(timeout), 0);
      end

      // Fairness: all request, each owner drops for one cycle after 3 cycles.
      step(1'b0, 1'b1, 4'b0000);
      for (int i = 0; i < 30; i++) begin
         rq_f = 4'b1111;
         if (m_owner >= 0 && m_held == 3) rq_f[m_owner] = 1'b0;
         step(1'b1, 1'b1, rq_f);
         obs_g.push_back(int'(gnt));
      end
      zeros = 0;
      nruns = 0;
      for (int i = 0; i < obs_g.size(); i++) begin
         if (obs_g[i] != 0) begin
            if (i == 0 || obs_g[i-1] != obs_g[i]) begin
               if (nruns > 0) chk("fair_gap", zeros, 1);
               if (nruns < 5) chk($sformatf("fair_order%0d", nruns), obs_g[i], 1 << (nruns % 4));
               nruns++;
            end
            zeros = 0;
         end else begin
            zeros++;
         end
      end
      chk("fair_runs_ge5", int'(nruns >= 5), 1);

      // Watchdog: req=0011 held after reset.
      step(1'b0, 1'b1, 4'b0000);
      for (int i = 0; i < 11; i++) begin
         step(1'b1, 1'b1, 4'b0011);
         obs_t.push_back(int'(gnt) * 2 + int'(timeout));
      end
      for (int i = 0; i < 11; i++) begin
`ifdef ARB_RR4_TIMEOUT_EN
         chk($sformatf("wd_cycle%0d", i), obs_t[i],
             (i < 4) ? 2 : (i == 4) ? 1 : (i < 9) ? 4 : (i == 9) ? 1 : 2);
`else
         chk($sformatf("wd_cycle%0d", i), obs_t[i], 2);
`endif
      end

      // Randomized traffic with sticky requests.
      rq_r = 4'b0000;
      step(1'b0, 1'b1, 4'b0000);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) rq_r = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0), rq_r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arb_rr4.md
# arb_rr4

Four-requester round-robin arbiter that shares one resource (e.g. a 4-way enable-decoded bus or output) between requesters 0..3. Issues a registered one-hot grant, holds it until the owner releases, then rotates priority. It sits in front of the shared datapath and drives its enable and select lines.

## Interface

- `MAX_HOLD`, default 16: maximum consecutive grant cycles when the timeout feature is compiled in; legal range 2..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `en` input 1: arbiter enable; 0 forces no grant.
- `req` input 4: request vector, bit i = requester i; level-held while the requester wants or owns the resource.
- `gnt` output 4: one-hot grant, or 0000; registered.
- `gnt_idx` output 2: index of the current or last owner; registered.
- `valid` output 1: 1 when `gnt` != 0000; registered.
- `timeout` output 1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation

- The clock is `clk`. Reset is synchronous and active-low on `rst_n`, sampled only on the rising edge of `clk`.
- Reset values:
  - `gnt` = 0000, `gnt_idx` = 00, `valid` = 0, `timeout` = 0.
  - Internal priority pointer `ptr` = 0. State = IDLE, hold counter = 0.
- **IDLE:**
  - If `en`=1 and `req` != 0000, grant the first set bit scanning `ptr`, `ptr`+1, … mod 4. Load `gnt`, `gnt_idx`, `valid`=1, then go to GRANT.
  - Otherwise stay in IDLE with `gnt` = 0000.
- **GRANT:**
  - Hold `gnt` and `gnt_idx` stable while `en`=1 and `req[gnt_idx]`=1.
  - Release on `req[gnt_idx]`=0, `en`=0, or watchdog expiry. On release: `gnt` = 0000, `valid` = 0, `ptr` = `gnt_idx`+1 mod 4 (wraps 3→0), then return to IDLE.
  - `gnt_idx` keeps the last owner after release.
- Only two states exist; no grant is issued in the release cycle. This gives exactly one idle cycle between consecutive owners.
- Requests from non-owners during GRANT are ignored; they are arbitrated in the next IDLE cycle.
- Rising and falling request edges within the same cycle have no special meaning. Only the level sampled at the clock edge matters.
- `gnt` is never multi-hot. `valid` equals the OR-reduction of `gnt` in every cycle.

## Timing

- Grant latency: `req` sampled high at edge N in IDLE → `gnt` high after edge N, i.e. visible in cycle N+1.
- Release latency: `req[gnt_idx]` sampled low at edge M → `gnt` = 0000 after edge M.
- Turnaround: a competing requester already asserting is granted after edge M+1.
- `en` deassertion behaves exactly like a release: same latency and pointer advance. With `en`=0, IDLE stays idle.
- Reset during GRANT: at the reset edge all outputs and `ptr` take their reset values, regardless of `req` or `en`. Reset has priority over every other event.
- Simultaneous release and watchdog expiry in the same cycle: treated as a watchdog revocation, so `timeout` pulses.

## Configuration

- Macro `ARB_RR4_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When `gnt` has been high for `MAX_HOLD` consecutive cycles, the arbiter releases at the next edge as described above. `timeout` is 1 for exactly the first IDLE cycle after that edge.
  - The revoked requester keeps `req` high and competes normally, so it cannot win again before every other asserted requester has been served.
- **Undefined:** no counter is built, `timeout` is tied to 0, and grants are unbounded. `MAX_HOLD` is ignored.

## Test plan

- **Reset then single request.** `req`=0100, `en`=1 → `gnt`=0100, `gnt_idx`=10 one cycle later. Drop `req` → `gnt`=0000 next cycle; `ptr` then favours requester 3.
- **Fairness.** All requesters hold `req`=1111, and each owner drops its request for 1 cycle after 3 grant cycles → grant order 0001, 0010, 0100, 1000, 0001, with exactly one `gnt`=0000 cycle between owners.
- **Enable low.** `en`=0 with `req`=1111 → `gnt` stays 0000. Drop `en` mid-grant of requester 1 → `gnt`=0000 next cycle; the next grant goes to requester 2.
- **Reset mid-grant.** `rst_n`=0 for one edge while `gnt`=1000 → `gnt`=0000, `gnt_idx`=00, `valid`=0. With `req`=1001 after reset, requester 0 wins first.
- **Timeout (with `ARB_RR4_TIMEOUT_EN`, `MAX_HOLD`=4).** `req`=0011 held → `gnt`=0001 for exactly 4 cycles, then one idle cycle with `timeout`=1, then `gnt`=0010.
- **Without macro, same stimulus** → `gnt`=0001 held indefinitely and `timeout` is always 0.
